// File: rtl/uart_prog_loader_if.sv
// Program-write port between the serial loader and instruction memory.
//   upg_wen_o : one-cycle write strobe
//   upg_adr_o : word address of the current write
//   upg_dat_o : 32-bit write data, valid while upg_wen_o is high
// master = loader side (drives), slave = memory side (receives).
interface uart_prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;

    modport master (output upg_wen_o, output upg_adr_o, output upg_dat_o);
    modport slave  (input  upg_wen_o, input  upg_adr_o, input  upg_dat_o);
endinterface

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives a length-prefixed byte stream on a UART
// line, assembles little-endian 32-bit words and writes them one per strobe
// into instruction memory starting at word address 0.
// Ports:
//   clock     : single rising-edge clock (UART domain)
//   rst_n     : asynchronous active-low reset
//   start_pg  : one-cycle pulse entering load mode
//   rx        : UART receive line, idle high, asynchronous
//   upg       : program-write port (master side)
//   busy      : load in progress
//   done      : last load completed (sticky until next start_pg)
//   frame_err : stop-bit error seen during a load (sticky)
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 180,
    parameter int ADDR_W       = 14
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                start_pg,
    input  logic                rx,
    uart_prog_loader_if.master  upg,
    output logic                busy,
    output logic                done,
    output logic                frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_LEN, L_DATA, L_DONE, L_ERR} ld_state_t;

    // ------------------------------------------------------------------
    // rx synchronizer; rx_prev gives the previous synchronized sample for
    // falling-edge detection in R_IDLE.
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic             byte_vld, byte_vld_n;
    logic             byte_err, byte_err_n;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            byte_vld <= 1'b0;
            byte_err <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            clk_cnt  <= clk_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            byte_vld <= byte_vld_n;
            byte_err <= byte_err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        clk_cnt_n  = clk_cnt + 1'b1;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        byte_vld_n = 1'b0;
        byte_err_n = 1'b0;
        case (rx_state)
            R_IDLE: begin
                clk_cnt_n = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_n = R_START;
                    bit_cnt_n  = '0;
                end
            end
            R_START: begin
                // Mid-bit check of the start bit filters short glitches.
                if (clk_cnt == HALF_M1) begin
                    clk_cnt_n  = '0;
                    rx_state_n = rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_sync, shift[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        rx_state_n = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (clk_cnt == FULL_M1) begin
                    clk_cnt_n  = '0;
                    rx_state_n = R_IDLE;
                    byte_vld_n = rx_sync;
                    byte_err_n = !rx_sync;
                end
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t         ld_state, ld_state_n;
    logic [1:0]        idx, idx_n;
    logic [15:0]       len, len_n;
    logic [15:0]       word_cnt, word_cnt_n;
    logic [ADDR_W-1:0] adr, adr_n;
    logic [23:0]       asm_q, asm_n;
    logic [31:0]       dat, dat_n;
    logic              wen, wen_n;
    logic              ferr, ferr_n;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ld_state <= L_IDLE;
            idx      <= '0;
            len      <= '0;
            word_cnt <= '0;
            adr      <= '0;
            asm_q    <= '0;
            dat      <= '0;
            wen      <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            ld_state <= ld_state_n;
            idx      <= idx_n;
            len      <= len_n;
            word_cnt <= word_cnt_n;
            adr      <= adr_n;
            asm_q    <= asm_n;
            dat      <= dat_n;
            wen      <= wen_n;
            ferr     <= ferr_n;
        end
    end

    always_comb begin
        ld_state_n = ld_state;
        idx_n      = idx;
        len_n      = len;
        word_cnt_n = word_cnt;
        adr_n      = adr;
        asm_n      = asm_q;
        dat_n      = dat;
        wen_n      = 1'b0;
        ferr_n     = ferr;
        case (ld_state)
            L_IDLE, L_DONE, L_ERR: begin
                if (start_pg) begin
                    ld_state_n = L_LEN;
                    idx_n      = '0;
                    len_n      = '0;
                    word_cnt_n = '0;
                    adr_n      = '0;
                    ferr_n     = 1'b0;
                end
            end
            L_LEN: begin
                if (byte_err) begin
                    ferr_n     = 1'b1;
                    ld_state_n = L_ERR;
                end else if (byte_vld) begin
                    if (idx == 2'd0) begin
                        len_n[7:0] = shift;
                        idx_n      = 2'd1;
                    end else begin
                        len_n[15:8] = shift;
                        idx_n       = 2'd0;
                        ld_state_n  = ({shift, len[7:0]} == 16'd0) ? L_DONE : L_DATA;
                    end
                end
            end
            L_DATA: begin
                // The strobe cycle advances address/count and decides completion.
                if (wen) begin
                    adr_n      = adr + 1'b1;
                    word_cnt_n = word_cnt + 16'd1;
                    if (word_cnt + 16'd1 == len) begin
                        ld_state_n = L_DONE;
                    end
                end
                if (byte_err) begin
                    ferr_n     = 1'b1;
                    ld_state_n = L_ERR;
                end else if (byte_vld) begin
                    idx_n = idx + 1'b1;
                    case (idx)
                        2'd0: asm_n[7:0]   = shift;
                        2'd1: asm_n[15:8]  = shift;
                        2'd2: asm_n[23:16] = shift;
                        default: begin
                            // Separate assembly register keeps upg_dat_o
                            // stable between writes.
                            dat_n = {shift, asm_q};
                            wen_n = 1'b1;
                        end
                    endcase
                end
            end
            default: ld_state_n = L_IDLE;
        endcase
    end

    assign upg.upg_wen_o = wen;
    assign upg.upg_adr_o = adr;
    assign upg.upg_dat_o = dat;
    assign busy          = (ld_state == L_LEN) || (ld_state == L_DATA);
    assign done          = (ld_state == L_DONE);
    assign frame_err     = ferr;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

    localparam int CPB = 4;
    localparam int AW  = 2;

    logic clock = 1'b0;
    logic rst_n;
    logic start_pg;
    logic rx;
    logic busy, done, frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_prog_loader_if #(.ADDR_W(AW)) upg ();

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start_pg  (start_pg),
        .rx        (rx),
        .upg       (upg),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    // Write capture: every strobe cycle is logged; a strobe must never last
    // longer than one cycle.
    logic [AW-1:0] wr_adr_q[$];
    logic [31:0]   wr_dat_q[$];
    logic          wen_prev = 1'b0;
    logic [31:0]   words[$];

    always @(negedge clock) begin
        if (wen_prev) begin
            n_checks++;
            if (upg.upg_wen_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wen_width: wen=%b in cycle after a strobe, required 0", upg.upg_wen_o);
            end
        end
        if (upg.upg_wen_o === 1'b1) begin
            wr_adr_q.push_back(upg.upg_adr_o);
            wr_dat_q.push_back(upg.upg_dat_o);
        end
        wen_prev = (upg.upg_wen_o === 1'b1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(CPB);
        rx = 1'b1;
    endtask

    task automatic gap();
        wait_cycles($urandom_range(0, 3));
    endtask

    task automatic pulse_start(input bit chk, input string name);
        start_pg = 1'b1;
        if (chk) begin
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_pre: busy=%b, required 0", name, busy);
            end
        end
        wait_cycles(1);
        start_pg = 1'b0;
        if (chk) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after_start: busy=%b done=%b frame_err=%b, required 1 0 0",
                         name, busy, done, frame_err);
            end
        end
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 8 * CPB && done !== 1'b1; k++) wait_cycles(1);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s completion: done=%b busy=%b frame_err=%b, required 1 0 0",
                     name, done, busy, frame_err);
        end
    endtask

    // Reference: word i of the stream lands at address i mod 2^AW.
    task automatic check_writes(input string name);
        logic [AW-1:0] ea;
        n_checks++;
        if (wr_adr_q.size() != words.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wr_adr_q.size(), words.size());
        end
        for (int i = 0; i < words.size() && i < wr_adr_q.size(); i++) begin
            ea = AW'(i % (1 << AW));
            n_checks++;
            if (wr_adr_q[i] !== ea || wr_dat_q[i] !== words[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: adr=%0d dat=%h, required adr=%0d dat=%h",
                         name, i, wr_adr_q[i], wr_dat_q[i], ea, words[i]);
            end
        end
    endtask

    task automatic do_load(input string name, input int mid_start, input bit glitch);
        int n;
        logic [31:0] w;
        n = words.size();
        wr_adr_q.delete();
        wr_dat_q.delete();
        pulse_start(1'b1, name);
        if (glitch) begin
            rx = 1'b0;
            wait_cycles(1);
            rx = 1'b1;
            wait_cycles(4 * CPB);
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || upg.upg_wen_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s glitch: busy=%b done=%b wen=%b, required 1 0 0",
                         name, busy, done, upg.upg_wen_o);
            end
        end
        send_byte(n[7:0], 1'b1);
        gap();
        send_byte(n[15:8], 1'b1);
        gap();
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], 1'b1);
                gap();
            end
            if (i == mid_start) pulse_start(1'b0, name);
        end
        wait_done(name);
        check_writes(name);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx       = 1'b1;
        start_pg = 1'b0;
        wait_cycles(3);
        n_checks++;
        if ({upg.upg_wen_o, upg.upg_adr_o, upg.upg_dat_o, busy, done, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: wen=%b adr=%0d dat=%h busy=%b done=%b ferr=%b, required all 0",
                     upg.upg_wen_o, upg.upg_adr_o, upg.upg_dat_o, busy, done, frame_err);
        end
        rst_n = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_basic();
        words = '{32'hDEADBEEF, 32'h12345678};
        do_load("basic", -1, 1'b0);
    endtask

    task automatic test_zero_len();
        wr_adr_q.delete();
        wr_dat_q.delete();
        pulse_start(1'b1, "zero_len");
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len early: done=%b busy=%b, required 0 1", done, busy);
        end
        words.delete();
        wait_done("zero_len");
        check_writes("zero_len");
    endtask

    task automatic test_glitch();
        words = '{32'hCAFEF00D};
        do_load("glitch", -1, 1'b1);
    endtask

    task automatic test_frame_err();
        wr_adr_q.delete();
        wr_dat_q.delete();
        pulse_start(1'b1, "frame_err");
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        wait_cycles(2 * CPB);
        n_checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err flags: frame_err=%b busy=%b done=%b, required 1 0 0",
                     frame_err, busy, done);
        end
        n_checks++;
        if (wr_adr_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_err writes: got %0d, required 0", wr_adr_q.size());
        end
        // Restart clears frame_err (checked inside pulse_start).
        words.delete();
        do_load("frame_err_restart", -1, 1'b0);
    endtask

    task automatic test_reset_midload();
        wr_adr_q.delete();
        wr_dat_q.delete();
        pulse_start(1'b1, "reset_mid");
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({upg.upg_wen_o, upg.upg_adr_o, upg.upg_dat_o, busy, done, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: wen=%b adr=%0d dat=%h busy=%b done=%b ferr=%b, required all 0",
                     upg.upg_wen_o, upg.upg_adr_o, upg.upg_dat_o, busy, done, frame_err);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(20 * CPB);
        n_checks++;
        if (wr_adr_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid after_release: writes=%0d busy=%b, required 0 0",
                     wr_adr_q.size(), busy);
        end
        words = '{32'h0BADC0DE};
        do_load("reset_mid_reload", -1, 1'b0);
    endtask

    task automatic test_wrap();
        words = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005};
        do_load("wrap", 1, 1'b0);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 7);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            do_load($sformatf("random%0d", r), -1, 1'b0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        start_pg = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_glitch();
        test_frame_err();
        test_reset_midload();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
